// File: rtl/display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit gets SCAN_DIV cycles, and the first BLANK_CYCLES of each are dark to suppress ghosting.
module display_scanner #(
  parameter logic [31:0] SCAN_DIV     = 32'd200000,
  parameter logic [31:0] BLANK_CYCLES = 32'd16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit_sel,
  output logic        frame_tick
);

  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] snap_digits_q, snap_digits_d;
  logic [3:0]  snap_dp_q, snap_dp_d;
  logic        eof_q, eof_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;
  logic [1:0]  digit_sel_q, digit_sel_d;
  logic        frame_tick_q, frame_tick_d;

  logic [3:0]  hi_zero;
  logic [3:0]  cur_nib;
  logic        suppress;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // hi_zero[i]: snapshot nibble i and every nibble above it are zero
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hi_zero
      assign hi_zero[gi] = (snap_digits_q[15:4*gi] == '0);
    end
  endgenerate

  assign cur_nib  = snap_digits_q[{idx_q, 2'b00} +: 4];
  assign suppress = lz_blank && (idx_q != 2'd0) && hi_zero[idx_q];

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    eof_d         = 1'b0;
    if (!enable) begin
      cnt_d         = '0;
      idx_d         = '0;
      snap_digits_d = digits;
      snap_dp_d     = dp;
    end else if (cnt_q == SCAN_DIV - 32'd1) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        eof_d         = 1'b1;
        snap_digits_d = digits;
        snap_dp_d     = dp;
      end
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Outputs decode the current cnt/idx and are registered, so the tick is
  // delayed one more cycle to line up with digit 0's first blank output.
  always_comb begin
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_n_d       = 1'b1;
    digit_sel_d  = 2'd0;
    frame_tick_d = enable & eof_q;
    if (enable) begin
      digit_sel_d = idx_q;
      if (cnt_q >= BLANK_CYCLES) begin
        an_d   = ~(4'b0001 << idx_q);
        seg_d  = suppress ? 7'h7F : glyph(cur_nib);
        dp_n_d = ~snap_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      eof_q         <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_n_q        <= 1'b1;
      digit_sel_q   <= 2'd0;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      eof_q         <= eof_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      digit_sel_q   <= digit_sel_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign digit_sel  = digit_sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: directed scenarios plus random digits,
// compared every cycle against a frame-position model of the scan.
module tb_display_scanner;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * SD;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // model: position within the frame (in decode cycles), captured snapshot, end-of-frame flag
  int          m_t;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_eof;

  display_scanner #(.SCAN_DIV(32'(SD)), .BLANK_CYCLES(32'(BC))) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .digits(digits), .dp(dp),
    .lz_blank(lz_blank), .an(an), .seg(seg), .dp_n(dp_n), .digit_sel(digit_sel),
    .frame_tick(frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp_n), 32'd1);
    chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  task automatic model_reset();
    m_t = 0; m_dig = '0; m_dp = '0; m_eof = 1'b0;
  endtask

  // One clock: predict the registered outputs from the current inputs and frame position.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_tick;
    logic [1:0] e_sel;
    int         slot, ph;
    logic [3:0] nib;
    logic [15:0] upper;
    logic       supp;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_sel = 2'd0; e_tick = 1'b0;
    if (enable) begin
      slot   = m_t / SD;
      ph     = m_t % SD;
      e_sel  = 2'(slot);
      e_tick = m_eof;
      if (ph >= BC) begin
        e_an  = ~(4'b0001 << slot);
        nib   = m_dig[slot*4 +: 4];
        upper = m_dig >> (slot * 4);
        supp  = lz_blank && (slot != 0) && (upper == 16'd0);
        e_seg = supp ? 7'h7F : GLYPH[nib];
        e_dp  = ~m_dp[slot];
      end
      m_eof = (m_t == FRAME - 1);
      if (m_eof) begin
        m_dig = digits;
        m_dp  = dp;
      end
      m_t = (m_t + 1) % FRAME;
    end else begin
      m_t = 0; m_eof = 1'b0; m_dig = digits; m_dp = dp;
    end
    @(posedge clock); #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp_n", 32'(dp_n), 32'(e_dp));
    chk("digit_sel", 32'(digit_sel), 32'(e_sel));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // advance until the model's next decode cycle sits at the given slot/phase (bounded)
  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * FRAME && m_t != pos; i++) step();
    chk("run_to_reached", 32'(m_t), 32'(pos));
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b1; digits = '0; dp = '0; lz_blank = 1'b0;
    model_reset();

    // reset with enable high: dark immediately and while held
    #2 reset_n = 1'b0;
    #1 chk_dark("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk_dark("rst_hold");
      chk("rst_sel", 32'(digit_sel), 32'd0);
    end
    digits = 16'h1234; dp = 4'b0001;
    #2 reset_n = 1'b1;
    model_reset();

    // basic scan of 1234 across several frames (snapshot of 1234 lands at first frame end)
    run(3 * FRAME);

    // leading-zero cases
    lz_blank = 1'b1;
    digits = 16'h0050; dp = 4'b0000;
    run(2 * FRAME);
    digits = 16'h0000;
    run(2 * FRAME);
    digits = 16'h0A00; dp = 4'b0100;
    run(2 * FRAME);
    lz_blank = 1'b0;

    // mid-frame change must not tear the current frame
    digits = 16'h1111;
    run(2 * FRAME);
    run_to(1 * SD + 3);
    digits = 16'h2222;
    run(2 * FRAME);

    // drop enable during the drive phase of digit 2
    run_to(2 * SD + 4);
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(FRAME + 4);

    // asynchronous reset during the drive phase of digit 3
    run_to(3 * SD + 4);
    #2 reset_n = 1'b0;
    #1 chk_dark("rst_mid_async");
    chk("rst_mid_sel", 32'(digit_sel), 32'd0);
    @(posedge clock); #1;
    chk_dark("rst_mid_hold");
    #2 reset_n = 1'b1;
    model_reset();
    run(2 * FRAME);

    // randomized: random digits/dp/lz each frame, random mid-frame edits and enable drops
    for (int f = 0; f < 8; f++) begin
      lz_blank = 1'($urandom_range(0, 1));
      digits   = 16'($urandom);
      if ($urandom_range(0, 2) == 0) digits = digits & 16'h00FF;
      dp       = 4'($urandom);
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
        if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
        if ($urandom_range(0, 59) == 0) enable = 1'b0;
        else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
        step();
      end
    end
    enable = 1'b1;
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It runs on the main board clock and generates its own per-digit slot timing with an internal divider, so it needs no separate scan-clock output. Each frame it captures a snapshot of four hex/BCD nibbles and their decimal points, then drives one digit at a time. A blanking interval between digits suppresses ghosting, and optional leading-zero suppression blanks unused high digits. It sits between the counter/ALU datapaths and the display pins.

## Interface

Parameters:
- SCAN_DIV, 32'd200000: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYCLES, 32'd16: cycles at the start of each slot with all anodes off. Must be < SCAN_DIV.

Ports:
- clock, input, 1: main board clock; all logic on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: 1 = scan; 0 = display dark and scan state held at start.
- digits, input, 16: four nibbles. [3:0] is digit 0 (rightmost); [15:12] is digit 3 (leftmost).
- dp, input, 4: decimal point per digit, 1 = lit. dp[0] belongs to digit 0.
- lz_blank, input, 1: 1 = suppress leading zeros.
- an, output, 4: anodes, active-low. an[i] enables digit i.
- seg, output, 7: segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp_n, output, 1: decimal point, active-low.
- digit_sel, output, 2: index of the digit currently being scanned (debug).
- frame_tick, output, 1: one-cycle pulse at the end of each frame.

## Operation

Internal state:
- cnt: 32-bit slot counter.
- idx: 2-bit digit index.
- snap_digits / snap_dp: snapshot registers for digits and dp.

Scan sequence, while enable = 1:
- cnt increments every cycle.
- When cnt == SCAN_DIV-1: cnt wraps to 0 and idx increments (3 wraps to 0).
- End of frame is the cycle with cnt == SCAN_DIV-1 and idx == 3. In that cycle, snap_* load from digits/dp and frame_tick = 1 for one cycle.

Per-slot decode:
- Blank phase, cnt < BLANK_CYCLES: an = 4'b1111, seg = 7'h7F, dp_n = 1.
- Drive phase, cnt ≥ BLANK_CYCLES: an has only bit idx low. seg = glyph(snap nibble idx). dp_n = ~snap_dp[idx].

Glyph table (hex, active-low gfedcba):
- 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
- 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E

Leading-zero suppression, with lz_blank = 1:
- Digit i (i ≥ 1) is suppressed when its snapshot nibble and every higher nibble are 0.
- A suppressed digit shows seg = 7'h7F, but its anode is still driven.
- Digit 0 is never suppressed.
- dp still follows snap_dp.

Disable, with enable = 0:
- cnt = 0, idx = 0.
- snap_* load from the inputs every cycle.
- Outputs are dark and frame_tick = 0.
- When enable returns to 1, scanning restarts at digit 0 in its blank phase.

## Timing

Reset values (asynchronous, immediate on reset_n low): an = 4'b1111, seg = 7'h7F, dp_n = 1, digit_sel = 0, frame_tick = 0. Internally cnt = 0, idx = 0, snap_* = 0.

Output registration:
- an, seg, dp_n and digit_sel are registered: they reflect the decode of the cnt/idx values held in the previous cycle.
- frame_tick is also registered. It is high in the cycle after the end-of-frame condition, in the same cycle as the first blank-phase output of digit 0.
- The new snapshot is first visible on the display when digit 0 enters its drive phase.

Period per digit slot:
- SCAN_DIV cycles in total: BLANK_CYCLES dark, then SCAN_DIV − BLANK_CYCLES lit.
- Frame period = 4·SCAN_DIV cycles.

Boundary behaviour:
- Changes to digits/dp in mid-frame have no effect until the next end of frame. No tearing is allowed.
- enable falling mid-slot: the display is dark from the next cycle on.
- reset_n asserted mid-scan: outputs go to reset values immediately. After release, scanning starts at digit 0 in its blank phase.

## Test plan

All scenarios use SCAN_DIV = 8, BLANK_CYCLES = 2.

1. Reset with enable = 1 → an = 1111, seg = 7F, dp_n = 1, frame_tick = 0 while reset_n = 0.
2. digits = 16'h1234, dp = 4'b0001, lz_blank = 0 → an cycles through 1110, 1101, 1011, 0111. Each is low for 6 cycles, preceded by 2 cycles of 1111. seg shows 19, 30, 24, 79 in that order. dp_n = 0 only for digit 0. frame_tick pulses every 32 cycles.
3. Leading-zero cases with lz_blank = 1:
   - digits = 16'h0050 → digits 3 and 2 show seg = 7F; digit 1 shows 12; digit 0 shows 40.
   - digits = 16'h0000 → only digit 0 shows 40.
   - digits = 16'h0A00 → digit 2 shows 08.
4. Change digits from 16'h1111 to 16'h2222 during idx = 1 → remaining slots of the current frame still show 79. The new value 24 appears only after the next frame_tick.
5. Drop enable during the drive phase of digit 2, hold it low for 5 cycles, then raise it → an = 1111 from the next cycle. After re-enable, 2 blank cycles follow, then an = 1110.
6. Assert reset_n low during the drive phase of digit 3 → an = 1111 immediately, before the next clock edge. After release, the sequence restarts at digit 0.
